// File: rtl/cmd_issuer_pkg.sv
// Shared types for the command issuer: packed command layout, rank status
// encoding, read/write encoding and the issue FSM states.
package cmd_issuer_pkg;

    localparam logic [3:0] PM_IDLE  = 4'b0000;
    localparam logic       RW_WRITE = 1'b0;
    localparam logic       RW_READ  = 1'b1;

    typedef struct packed {
        logic        r_w;
        logic        rsvd30;
        logic [12:0] row;
        logic        rsvd16;
        logic        burst_length;
        logic        rsvd14;
        logic        auto_precharge;
        logic [9:0]  col;
        logic [2:0]  bank;
    } command_t;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_SETUP   = 2'd1,
        S_ISSUE   = 2'd2,
        S_WAIT_RD = 2'd3
    } state_e;

    // One queued request: target rank, pre-packed command, write payload.
    typedef struct packed {
        logic [1:0]   rank;
        command_t     cmd;
        logic [127:0] wdata;
    } req_entry_t;

    localparam int ENTRY_W = $bits(req_entry_t);

    function automatic command_t pack_cmd(input logic        rw,
                                          input logic [12:0] row,
                                          input logic        burst,
                                          input logic        ap,
                                          input logic [9:0]  col,
                                          input logic [2:0]  bank);
        command_t c;
        c                = '0;
        c.r_w            = rw;
        c.row            = row;
        c.burst_length   = burst;
        c.auto_precharge = ap;
        c.col            = col;
        c.bank           = bank;
        return c;
    endfunction

endpackage

// File: rtl/cmd_issuer_fifo.sv
// Request queue: DEPTH entries of WIDTH bits, head visible combinationally
// on dout_o. DEPTH must be a power of two so the pointers wrap naturally.
module cmd_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push_i,
    input  logic [WIDTH-1:0] din_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] dout_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW    = $clog2(DEPTH);
    localparam int CNT_W = AW + 1;
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q;
    logic [AW-1:0]    rd_ptr_q;
    logic [CNT_W-1:0] count_q;

    always_ff @(posedge clk) begin
        if (push_i) begin
            mem_q[wr_ptr_q] <= din_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (push_i) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop_i) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            case ({push_i, pop_i})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

    assign dout_o  = mem_q[rd_ptr_q];
    assign full_o  = (count_q == FULL_CNT);
    assign empty_o = (count_q == '0);

endmodule

// File: rtl/cmd_issuer.sv
// Queues host requests and issues them one at a time to the rank demux,
// waiting for the addressed rank to go idle and for read data to return.
module cmd_issuer
    import cmd_issuer_pkg::*;
#(
    parameter int FIFO_DEPTH = 4,
    parameter int RD_TIMEOUT = 255
) (
    input  logic         clk,
    input  logic         power_on_rst,
    input  logic         req_valid,
    output logic         req_ready,
    input  logic         req_rw,
    input  logic [1:0]   req_rank,
    input  logic [2:0]   req_bank,
    input  logic [12:0]  req_row,
    input  logic [9:0]   req_col,
    input  logic         req_burst,
    input  logic         req_auto_pre,
    input  logic [127:0] req_wdata,
    output logic [33:0]  command,
    output logic         valid,
    output logic [127:0] write_data,
    input  logic [3:0]   ba_cmd_pm,
    input  logic [127:0] read_data,
    input  logic         read_data_valid,
    output logic         rsp_valid,
    output logic [127:0] rsp_rdata,
    output logic         rsp_timeout,
    output logic [1:0]   dbg_state_o
);

    localparam logic [7:0] TIMEOUT_LAST = 8'(RD_TIMEOUT - 1);

    state_e       state_q;
    logic         ready_en_q;
    logic [33:0]  command_q;
    logic [127:0] wdata_q;
    logic [7:0]   tmo_cnt_q;
    logic         rsp_valid_q;
    logic         rsp_timeout_q;
    logic [127:0] rsp_rdata_q;

    req_entry_t push_entry;
    req_entry_t head_entry;
    logic       push;
    logic       pop;
    logic       fifo_full;
    logic       fifo_empty;
    logic       accept;

    assign push_entry = '{rank:  req_rank,
                          cmd:   pack_cmd(req_rw, req_row, req_burst, req_auto_pre,
                                          req_col, req_bank),
                          wdata: req_wdata};

    // Handshake: a request transfers on any cycle with req_valid && req_ready.
    assign req_ready = ready_en_q && !fifo_full;
    assign push      = req_valid && req_ready;
    assign pop       = (state_q == S_IDLE) && !fifo_empty;

    cmd_fifo #(
        .WIDTH (ENTRY_W),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst     (power_on_rst),
        .push_i  (push),
        .din_i   (push_entry),
        .pop_i   (pop),
        .dout_o  (head_entry),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // valid must coincide with the rank status of the same cycle, so it is
    // decoded from the registered state rather than registered itself.
    assign accept     = (state_q == S_ISSUE) && (ba_cmd_pm == PM_IDLE);
    assign valid      = accept;
    assign write_data = (accept && command_q[31] == RW_WRITE) ? wdata_q : '0;

    always_ff @(posedge clk) begin
        if (power_on_rst) begin
            state_q       <= S_IDLE;
            ready_en_q    <= 1'b0;
            command_q     <= '0;
            wdata_q       <= '0;
            tmo_cnt_q     <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_rdata_q   <= '0;
        end else begin
            ready_en_q    <= 1'b1;
            rsp_valid_q   <= 1'b0;
            rsp_timeout_q <= 1'b0;
            rsp_rdata_q   <= '0;
            case (state_q)
                S_IDLE: begin
                    if (!fifo_empty) begin
                        command_q <= {head_entry.rank, head_entry.cmd};
                        wdata_q   <= head_entry.wdata;
                        state_q   <= S_SETUP;
                    end
                end
                S_SETUP: begin
                    state_q <= S_ISSUE;
                end
                S_ISSUE: begin
                    if (ba_cmd_pm == PM_IDLE) begin
                        command_q[31:0] <= '0;
                        tmo_cnt_q       <= '0;
                        state_q         <= (command_q[31] == RW_READ) ? S_WAIT_RD : S_IDLE;
                    end
                end
                S_WAIT_RD: begin
                    // Data arriving on the last allowed cycle beats the timeout.
                    if (read_data_valid) begin
                        rsp_valid_q <= 1'b1;
                        rsp_rdata_q <= read_data;
                        state_q     <= S_IDLE;
                    end else if (tmo_cnt_q == TIMEOUT_LAST) begin
                        rsp_valid_q   <= 1'b1;
                        rsp_timeout_q <= 1'b1;
                        state_q       <= S_IDLE;
                    end else begin
                        tmo_cnt_q <= tmo_cnt_q + 8'd1;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign command     = command_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_timeout = rsp_timeout_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_cmd_issuer.sv
// Directed bench for cmd_issuer: table of requests with hand-packed commands
// plus sequences for rank-busy stalls, read timeout, queue fill and reset.
module tb_cmd_issuer;
    import cmd_issuer_pkg::*;

    localparam int RD_TIMEOUT = 255;

    logic         clk = 1'b0;
    logic         power_on_rst;
    logic         req_valid;
    logic         req_ready;
    logic         req_rw;
    logic [1:0]   req_rank;
    logic [2:0]   req_bank;
    logic [12:0]  req_row;
    logic [9:0]   req_col;
    logic         req_burst;
    logic         req_auto_pre;
    logic [127:0] req_wdata;
    logic [33:0]  command;
    logic         valid;
    logic [127:0] write_data;
    logic [3:0]   ba_cmd_pm;
    logic [127:0] read_data;
    logic         read_data_valid;
    logic         rsp_valid;
    logic [127:0] rsp_rdata;
    logic         rsp_timeout;
    logic [1:0]   dbg_state;

    always #5 clk = ~clk;

    cmd_issuer #(
        .FIFO_DEPTH (4),
        .RD_TIMEOUT (RD_TIMEOUT)
    ) dut (
        .clk             (clk),
        .power_on_rst    (power_on_rst),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_rw          (req_rw),
        .req_rank        (req_rank),
        .req_bank        (req_bank),
        .req_row         (req_row),
        .req_col         (req_col),
        .req_burst       (req_burst),
        .req_auto_pre    (req_auto_pre),
        .req_wdata       (req_wdata),
        .command         (command),
        .valid           (valid),
        .write_data      (write_data),
        .ba_cmd_pm       (ba_cmd_pm),
        .read_data       (read_data),
        .read_data_valid (read_data_valid),
        .rsp_valid       (rsp_valid),
        .rsp_rdata       (rsp_rdata),
        .rsp_timeout     (rsp_timeout),
        .dbg_state_o     (dbg_state)
    );

    typedef struct {
        logic         rw;
        logic [1:0]   rank;
        logic [2:0]   bank;
        logic [12:0]  row;
        logic [9:0]   col;
        logic         burst;
        logic         ap;
        logic [127:0] wdata;
        int           rd_dly;
        logic [127:0] rdata;
        logic [33:0]  exp_cmd;
    } vec_t;

    vec_t         vecs[5];
    int           n_cmp = 0;
    int           n_err = 0;
    logic [33:0]  exp_q[$];
    logic [127:0] exp_d_q[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #2;
    endtask

    task automatic set_req(input int i);
        req_rw       = vecs[i].rw;
        req_rank     = vecs[i].rank;
        req_bank     = vecs[i].bank;
        req_row      = vecs[i].row;
        req_col      = vecs[i].col;
        req_burst    = vecs[i].burst;
        req_auto_pre = vecs[i].ap;
        req_wdata    = vecs[i].wdata;
        req_valid    = 1'b1;
    endtask

    // Waits for the next issue, checks it against the scoreboard and
    // completes the read return when the command is a read.
    task automatic drain_one();
        int           w;
        logic [33:0]  e_cmd;
        logic [127:0] e_dat;
        w = 0;
        settle();
        while (!valid && w < 20) begin
            step();
            settle();
            w++;
        end
        chk("drain_valid", valid, 1'b1);
        if (valid && exp_q.size() > 0) begin
            e_cmd = exp_q.pop_front();
            e_dat = exp_d_q.pop_front();
            chk("drain_cmd", command, e_cmd);
            if (e_cmd[31]) begin
                chk("drain_rd_wdata", write_data, 128'h0);
                step();
                read_data_valid = 1'b1;
                read_data       = e_dat;
                step();
                read_data_valid = 1'b0;
                read_data       = '0;
                settle();
                chk("drain_rsp_valid", rsp_valid, 1'b1);
                chk("drain_rsp_rdata", rsp_rdata, e_dat);
            end else begin
                chk("drain_wr_wdata", write_data, e_dat);
                step();
            end
        end
    endtask

    task automatic run_timeout(input int i, input logic with_data, input logic [127:0] d);
        logic early;
        early = 1'b0;
        set_req(i);
        step();
        req_valid = 1'b0;
        step();
        step();
        settle();
        chk("tmo_issue_valid", valid, 1'b1);
        step();
        for (int n = 1; n <= RD_TIMEOUT; n++) begin
            settle();
            if (rsp_valid) early = 1'b1;
            if (with_data && n == RD_TIMEOUT) begin
                read_data_valid = 1'b1;
                read_data       = d;
            end
            step();
        end
        read_data_valid = 1'b0;
        read_data       = '0;
        settle();
        chk("tmo_no_early_rsp", early, 1'b0);
        chk("tmo_rsp_valid", rsp_valid, 1'b1);
        chk("tmo_rsp_timeout", rsp_timeout, !with_data);
        chk("tmo_rsp_rdata", rsp_rdata, with_data ? d : 128'h0);
        chk("tmo_state_idle", dbg_state, 2'(S_IDLE));
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic         seen_v;
        logic         seen_r;
        logic [127:0] d;
        int           w;

        vecs[0] = '{1'b0, 2'd2, 3'd5, 13'h1ABC, 10'h155, 1'b0, 1'b0,
                    128'h0011_2233_4455_6677_8899_AABB_CCDD_EEFF, 0, 128'h0,
                    34'h2_3578_0AAD};
        vecs[1] = '{1'b1, 2'd1, 3'd3, 13'h0FFF, 10'h3FF, 1'b1, 1'b1,
                    128'h0, 6, 128'hDEAD_BEEF_0123_4567_89AB_CDEF_DEAD_BEEF,
                    34'h1_9FFE_BFFB};
        vecs[2] = '{1'b0, 2'd3, 3'd7, 13'h1FFF, 10'h000, 1'b1, 1'b0,
                    128'hFFFF_0000_FFFF_0000_1234_5678_9ABC_DEF0, 0, 128'h0,
                    34'h3_3FFE_8007};
        vecs[3] = '{1'b1, 2'd0, 3'd0, 13'h0000, 10'h001, 1'b0, 1'b1,
                    128'h0, 1, 128'hCAFE_F00D_0000_0000_0000_0000_5555_AAAA,
                    34'h0_8000_2008};
        vecs[4] = '{1'b0, 2'd1, 3'd2, 13'h0001, 10'h200, 1'b0, 1'b1,
                    128'hA5A5_A5A5_5A5A_5A5A_0F0F_0F0F_F0F0_F0F0, 0, 128'h0,
                    34'h1_0002_3002};

        power_on_rst    = 1'b1;
        req_valid       = 1'b0;
        req_rw          = 1'b0;
        req_rank        = '0;
        req_bank        = '0;
        req_row         = '0;
        req_col         = '0;
        req_burst       = 1'b0;
        req_auto_pre    = 1'b0;
        req_wdata       = '0;
        ba_cmd_pm       = PM_IDLE;
        read_data       = '0;
        read_data_valid = 1'b0;

        // Reset state
        step();
        step();
        settle();
        chk("rst_command", command, 34'h0);
        chk("rst_valid", valid, 1'b0);
        chk("rst_write_data", write_data, 128'h0);
        chk("rst_rsp_valid", rsp_valid, 1'b0);
        chk("rst_rsp_rdata", rsp_rdata, 128'h0);
        chk("rst_rsp_timeout", rsp_timeout, 1'b0);
        chk("rst_req_ready", req_ready, 1'b0);
        power_on_rst = 1'b0;
        step();
        settle();
        chk("post_rst_req_ready", req_ready, 1'b1);

        // Table: one request at a time with rank idle, exact cycle timing
        for (int i = 0; i < 5; i++) begin
            set_req(i);
            settle();
            chk("tbl_ready", req_ready, 1'b1);
            step();
            req_valid = 1'b0;
            step();
            settle();
            chk("tbl_setup_valid", valid, 1'b0);
            chk("tbl_setup_cmd", command, vecs[i].exp_cmd);
            step();
            settle();
            chk("tbl_issue_valid", valid, 1'b1);
            chk("tbl_issue_cmd", command, vecs[i].exp_cmd);
            chk("tbl_issue_wdata", write_data, vecs[i].rw ? 128'h0 : vecs[i].wdata);
            step();
            settle();
            chk("tbl_post_valid", valid, 1'b0);
            chk("tbl_post_cmd", command, {vecs[i].rank, 32'h0});
            chk("tbl_post_wdata", write_data, 128'h0);
            seen_r = 1'b0;
            if (vecs[i].rw) begin
                for (int k = 1; k < vecs[i].rd_dly; k++) begin
                    settle();
                    if (rsp_valid) seen_r = 1'b1;
                    step();
                end
                read_data_valid = 1'b1;
                read_data       = vecs[i].rdata;
                step();
                read_data_valid = 1'b0;
                read_data       = '0;
                settle();
                chk("tbl_rd_no_early", seen_r, 1'b0);
                chk("tbl_rsp_valid", rsp_valid, 1'b1);
                chk("tbl_rsp_rdata", rsp_rdata, vecs[i].rdata);
                chk("tbl_rsp_timeout", rsp_timeout, 1'b0);
                step();
                settle();
                chk("tbl_rsp_pulse", rsp_valid, 1'b0);
            end else begin
                for (int k = 0; k < 4; k++) begin
                    settle();
                    if (rsp_valid) seen_r = 1'b1;
                    step();
                end
                chk("tbl_wr_no_rsp", seen_r, 1'b0);
            end
        end

        // Rank busy for 10 cycles in ISSUE
        ba_cmd_pm = 4'b0010;
        set_req(0);
        step();
        req_valid = 1'b0;
        step();
        step();
        seen_v = 1'b0;
        for (int c = 0; c < 10; c++) begin
            settle();
            if (valid) seen_v = 1'b1;
            step();
        end
        settle();
        chk("busy_no_valid", seen_v, 1'b0);
        chk("busy_state", dbg_state, 2'(S_ISSUE));
        chk("busy_cmd_held", command, vecs[0].exp_cmd);
        ba_cmd_pm = PM_IDLE;
        settle();
        chk("busy_release_valid", valid, 1'b1);
        chk("busy_release_wdata", write_data, vecs[0].wdata);
        step();
        settle();
        chk("busy_after_valid", valid, 1'b0);
        chk("busy_after_state", dbg_state, 2'(S_IDLE));

        // Read timeout, then data on the timeout cycle itself
        d = 128'h1357_9BDF_2468_ACE0_1111_2222_3333_4444;
        run_timeout(3, 1'b0, 128'h0);
        step();
        run_timeout(1, 1'b1, d);
        step();

        // Fill the queue while the rank is busy, then drain in order
        ba_cmd_pm = 4'b0100;
        for (int i = 0; i < 5; i++) begin
            set_req(i);
            exp_q.push_back(vecs[i].exp_cmd);
            exp_d_q.push_back(vecs[i].rw ? vecs[i].rdata : vecs[i].wdata);
            settle();
            w = 0;
            while (!req_ready && w < 10) begin
                step();
                settle();
                w++;
            end
            chk("fill_ready", req_ready, 1'b1);
            step();
        end
        req_valid = 1'b0;
        settle();
        chk("fill_full_ready", req_ready, 1'b0);
        chk("fill_no_valid", valid, 1'b0);
        ba_cmd_pm = PM_IDLE;
        for (int i = 0; i < 5; i++) begin
            drain_one();
        end
        step();
        settle();
        chk("fill_ready_again", req_ready, 1'b1);

        // Reset while a read is outstanding and a write is queued
        set_req(1);
        step();
        set_req(2);
        step();
        req_valid = 1'b0;
        step();
        settle();
        chk("rstw_issue_valid", valid, 1'b1);
        step();
        settle();
        chk("rstw_in_wait", dbg_state, 2'(S_WAIT_RD));
        power_on_rst = 1'b1;
        step();
        power_on_rst = 1'b0;
        settle();
        chk("rstw_command", command, 34'h0);
        chk("rstw_valid", valid, 1'b0);
        chk("rstw_write_data", write_data, 128'h0);
        chk("rstw_rsp_valid", rsp_valid, 1'b0);
        chk("rstw_rsp_rdata", rsp_rdata, 128'h0);
        chk("rstw_rsp_timeout", rsp_timeout, 1'b0);
        chk("rstw_req_ready", req_ready, 1'b0);
        read_data_valid = 1'b1;
        read_data       = vecs[1].rdata;
        step();
        read_data_valid = 1'b0;
        read_data       = '0;
        seen_v = 1'b0;
        seen_r = 1'b0;
        for (int c = 0; c < RD_TIMEOUT + 20; c++) begin
            settle();
            if (valid) seen_v = 1'b1;
            if (rsp_valid) seen_r = 1'b1;
            step();
        end
        chk("rstw_no_rsp", seen_r, 1'b0);
        chk("rstw_no_issue", seen_v, 1'b0);
        settle();
        chk("rstw_ready_back", req_ready, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/cmd_issuer.md
CMD_ISSUER -- requirements
Module: cmd_issuer

Interface
REQ-001 Parameter FIFO_DEPTH, default 4, request-queue entries (power of two, at least 2).
REQ-002 Parameter RD_TIMEOUT, default 255, maximum cycles to wait for read data.
REQ-003 Ports are listed as: name, direction, width, meaning.
REQ-004 clk  in  1  single clock; all logic rises on posedge clk.
REQ-005 power_on_rst  in  1  reset, synchronous and active-high.
REQ-006 req_valid / req_ready  in / out  1 / 1  host request handshake; a transfer occurs when both are 1.
REQ-007 req_rw  in  1  request type: 0 = write, 1 = read.
REQ-008 req_rank, req_bank, req_row, req_col  in  2, 3, 13, 10  request address.
REQ-009 req_burst, req_auto_pre  in  1, 1  burst-length bit and auto-precharge bit.
REQ-010 req_wdata  in  128  write payload.
REQ-011 command  out  34  packed command to the rank-demux package.
REQ-012 valid  out  1  command strobe.
REQ-013 write_data  out  128  write payload to the rank-demux package.
REQ-014 ba_cmd_pm  in  4  status of the rank currently addressed by command[33:32].
REQ-015 read_data / read_data_valid  in  128 / 1  read return from the addressed rank.
REQ-016 rsp_valid  out  1  one-cycle response pulse.
REQ-017 rsp_rdata  out  128  read data for the response.
REQ-018 rsp_timeout  out  1  set with rsp_valid when the read timed out.

Function
REQ-019 Command packing is fixed:
- [33:32] rank; [31] r_w; [30] 0; [29:17] row; [16] 0;
- [15] burst_length; [14] 0; [13] auto_precharge; [12:3] col; [2:0] bank.
REQ-020 Accepted requests enter a FIFO of FIFO_DEPTH entries.
- req_ready = !full.
- A push while full is impossible by construction.
- A simultaneous push and pop while full is not allowed, because req_ready is already 0.
- Pointers wrap modulo FIFO_DEPTH.
REQ-021 The FSM has the states IDLE, SETUP, ISSUE and WAIT_RD.
REQ-022 IDLE: when the FIFO is non-empty, pop the head into the issue register and go to SETUP.
- Pop-to-SETUP takes 1 cycle.
REQ-023 SETUP: drive the packed head command with valid=0.
- Go to ISSUE in the next cycle.
- The cycle gives the ba_cmd_pm mux one cycle to select the target rank.
REQ-024 ISSUE: hold the command.
- Assert valid=1 for exactly the one cycle in which ba_cmd_pm == PM_IDLE.
- While ba_cmd_pm != PM_IDLE, stay in ISSUE with valid=0 and no timeout.
REQ-025 ISSUE exit on acceptance:
- A write returns to IDLE.
- A read goes to WAIT_RD and clears the timeout counter.
REQ-026 write_data equals the entry's wdata only in the valid cycle of a write; otherwise it is 0.
REQ-027 WAIT_RD: command[33:32] holds the read's rank, command[31:0]=0 and valid=0.
REQ-028 WAIT_RD data return:
- read_data_valid=1 produces, in the next cycle, rsp_valid=1 with rsp_rdata = the read_data captured in that cycle and rsp_timeout=0.
- The FSM then returns to IDLE.
REQ-029 WAIT_RD timeout: the counter (8 bits) increments each cycle.
- When it reaches RD_TIMEOUT without read_data_valid, emit rsp_valid=1, rsp_timeout=1, rsp_rdata=0, and go to IDLE.
- If read_data_valid coincides with the timeout cycle, data wins and the response is REQ-028.
REQ-030 Only one read is outstanding at a time.
- A write is never issued while in WAIT_RD.
REQ-031 read_data_valid outside WAIT_RD is ignored.
REQ-032 In IDLE, command[33:32] keeps the last issued rank and command[31:0]=0.
REQ-033 Write responses are not generated; rsp_valid pulses only for reads.

Reset
REQ-034 While power_on_rst=1 at a clock edge, all of the following are cleared:
- FSM = IDLE; FIFO empty; counter = 0.
- command = 0, valid = 0, write_data = 0.
- rsp_valid = 0, rsp_rdata = 0, rsp_timeout = 0.
- req_ready = 0.
REQ-035 req_ready rises in the first cycle after reset deasserts.
REQ-036 Reset mid-operation, including in ISSUE or WAIT_RD, abandons the in-flight request and all queued requests without emitting any response.

Structure
REQ-037 The shared package holds:
- command_t, the packed 32-bit struct in REQ-019 field order;
- PM_IDLE = 4'b0000;
- the R_W encoding constants;
- the FSM state enum.
REQ-038 The FIFO is one sub-module, cmd_fifo, parameterised by width and depth, with synchronous active-high reset.

Verification
REQ-039 Write to rank 2, bank 5, row 0x1ABC, col 0x155, ba_cmd_pm=0:
- valid is seen 2 cycles after the pop, command = {2'b10, packed};
- write_data = req_wdata; no rsp_valid.
REQ-040 Read to rank 1 with read_data_valid 6 cycles after valid, read_data = 128'hDEAD...BEEF:
- rsp_valid 1 cycle later with that data, rsp_timeout = 0.
REQ-041 Hold ba_cmd_pm = 4'b0010 for 10 cycles in ISSUE:
- valid stays 0 throughout;
- valid fires in the first cycle ba_cmd_pm = 0.
REQ-042 Read with no read_data_valid:
- rsp_valid with rsp_timeout = 1 and rsp_rdata = 0 exactly RD_TIMEOUT cycles after entering WAIT_RD;
- a read_data_valid on that same cycle gives data instead.
REQ-043 Push 5 requests back-to-back with ba_cmd_pm busy:
- req_ready drops after the queue fills;
- all 5 requests issue in order once ba_cmd_pm = 0.
REQ-044 Assert power_on_rst in WAIT_RD:
- all outputs are 0 the next cycle;
- no response is emitted later, even if read_data_valid arrives.
